// File: rtl/pwm_signal_writer.sv
// rtl/pwm_signal_writer.sv - servo/ESC PWM frame generator with double-buffered 8-bit command
module pwm_signal_writer #(
  parameter int TICK_DIV    = 196,
  parameter int BASE_TICKS  = 256,
  parameter int FRAME_TICKS = 5120,
  parameter int DUTY_WIDTH  = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic [DUTY_WIDTH-1:0] duty_in,
  input  logic                  duty_load,
  output logic                  pwm_out,
  output logic                  frame_start
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(FRAME_TICKS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] BASE_LAST  = TW'(BASE_TICKS - 1);
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {IDLE, BASE, VAR, LOW} state_t;

  state_t                  state, state_n;
  logic [PW-1:0]           presc;
  logic [TW-1:0]           tick_cnt;
  logic [DUTY_WIDTH-1:0]   hold, shadow;
  logic [TW-1:0]           high_last;
  logic                    tick;
  logic                    start;
  logic                    pwm_n;

  assign tick = (presc == PRESC_LAST);

  // Last tick of the high phase; FRAME_TICKS > BASE_TICKS+255 keeps this in range.
  assign high_last = BASE_LAST + TW'(shadow);

  always_comb begin
    state_n = state;
    pwm_n   = pwm_out;
    start   = 1'b0;
    case (state)
      IDLE: begin
        pwm_n = 1'b0;
        if (enable) start = 1'b1;
      end
      BASE: begin
        if (tick && tick_cnt == BASE_LAST) begin
          if (shadow != '0) begin
            state_n = VAR;
          end else begin
            state_n = LOW;
            pwm_n   = 1'b0;
          end
        end
      end
      VAR: begin
        if (tick && tick_cnt == high_last) begin
          state_n = LOW;
          pwm_n   = 1'b0;
        end
      end
      LOW: begin
        if (tick && tick_cnt == FRAME_LAST) begin
          if (enable) start = 1'b1;
          else        state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        pwm_n   = 1'b0;
      end
    endcase
    if (start) begin
      state_n = BASE;
      pwm_n   = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      presc       <= '0;
      tick_cnt    <= '0;
      hold        <= '0;
      shadow      <= '0;
    end else begin
      state       <= state_n;
      pwm_out     <= pwm_n;
      frame_start <= start;

      if (start || tick) presc <= '0;
      else               presc <= presc + PW'(1);

      if (start || state_n == IDLE) tick_cnt <= '0;
      else if (tick)                tick_cnt <= tick_cnt + TW'(1);

      // A load coinciding with the frame start goes straight into the shadow.
      if (start) shadow <= duty_load ? duty_in : hold;
      if (duty_load) hold <= duty_in;
    end
  end

endmodule

// File: tb/tb_pwm_signal_writer.sv
// tb/tb_pwm_signal_writer.sv - randomized and directed self-check of pwm_signal_writer against a frame-level model
module tb_pwm_signal_writer;

  localparam int D = 4;
  localparam int B = 8;
  localparam int F = 300;
  localparam int FRAME_CYC = F * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] duty = 8'd0;
  logic       load = 1'b0;
  logic       pwm;
  logic       fs;

  int checks = 0;
  int errors = 0;

  pwm_signal_writer #(
    .TICK_DIV(D), .BASE_TICKS(B), .FRAME_TICKS(F), .DUTY_WIDTH(8)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .enable(en), .duty_in(duty),
    .duty_load(load), .pwm_out(pwm), .frame_start(fs)
  );

  always #5 clk = ~clk;

  // Frame-level model: position within the frame in cycles, high length in cycles.
  bit  m_on = 0;
  bit  m_active = 0;
  int  m_pos = 0;
  int  m_high = 0;
  int  m_hold = 0;
  int  m_shadow = 0;
  bit  m_pwm = 0;
  bit  m_fs = 0;

  int  cyc = 0;
  int  high_cnt = 0;
  int  last_high = 0;
  int  last_fs_cyc = 0;
  int  last_period = 0;
  int  fs_total = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    bit last_cyc, st;
    if (rst) begin
      m_on = 1; m_active = 0; m_hold = 0; m_pos = 0;
      m_pwm = 0; m_fs = 0;
    end else begin
      last_cyc = m_active && (m_pos == FRAME_CYC - 1);
      st = en && (!m_active || last_cyc);
      if (st) begin
        m_shadow = load ? int'(duty) : m_hold;
        m_high   = (B + m_shadow) * D;
        m_pos    = 0;
        m_active = 1;
      end else if (last_cyc) begin
        m_active = 0;
      end else if (m_active) begin
        m_pos++;
      end
      if (load) m_hold = int'(duty);
      m_pwm = m_active && (m_pos < m_high);
      m_fs  = st;
    end
    #1;
    cyc++;
    if (m_on) begin
      check("pwm_out", int'(pwm), int'(m_pwm));
      check("frame_start", int'(fs), int'(m_fs));
    end
    if (pwm) high_cnt++;
    else if (high_cnt != 0) begin
      last_high = high_cnt;
      high_cnt  = 0;
    end
    if (fs) begin
      last_period = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
      fs_total++;
    end
  end

  task automatic wait_fs(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fs) begin
        got = 1;
        break;
      end
    end
    check("frame_start_timeout", int'(got), 1);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    duty = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int fs_snap;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_fs", int'(fs), 0);
    rst = 1'b0;

    // First frames with hold = 0
    en = 1'b1;
    wait_fs(10);
    wait_fs(FRAME_CYC + 10);
    check("t1_high", last_high, 32);
    check("t1_period", last_period, 1200);

    // Load 255 mid-frame: current frame unchanged, next widened
    repeat (100) @(negedge clk);
    pulse_load(8'd255);
    wait_fs(FRAME_CYC + 10);
    check("t2_cur_high", last_high, 32);
    wait_fs(FRAME_CYC + 10);
    check("t2_next_high", last_high, 1052);
    check("t2_period", last_period, 1200);

    // Shadow 20, then load 100 mid-pulse
    pulse_load(8'd20);
    wait_fs(FRAME_CYC + 10);
    repeat (50) @(negedge clk);
    pulse_load(8'd100);
    wait_fs(FRAME_CYC + 10);
    check("t3_cur_high", last_high, 112);
    wait_fs(FRAME_CYC + 10);
    check("t3_next_high", last_high, 432);

    // Drop enable 50 cycles into a frame
    repeat (50) @(negedge clk);
    en = 1'b0;
    fs_snap = fs_total;
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("t4_no_new_frame", fs_total - fs_snap, 0);
    check("t4_pwm_idle", int'(pwm), 0);
    check("t4_last_high", last_high, 432);

    // Reset during the high phase with enable held
    en = 1'b1;
    wait_fs(10);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_pwm", int'(pwm), 0);
    check("t5_rst_fs", int'(fs), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_restart_fs", int'(fs), 1);
    check("t5_restart_pwm", int'(pwm), 1);

    // Load on the exact frame-start edge
    repeat (FRAME_CYC - 1) @(negedge clk);
    pulse_load(8'd40);
    check("t6_fs_edge", int'(fs), 1);
    wait_fs(FRAME_CYC + 10);
    check("t6_high", last_high, 192);

    // Randomized traffic against the model
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      duty = 8'($urandom);
      load = ($urandom_range(0, 149) == 0);
      rst  = ($urandom_range(0, 5999) == 0);
      if ($urandom_range(0, 2499) == 0) en = ~en;
    end
    load = 1'b0;
    rst  = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
